// File: rtl/console_uart_tx.sv
// console_uart_tx -- memory-mapped console transmitter for the CPU debug bus.
// CPU byte writes to DATA are queued in a FIFO and sent on tx_o as 8N1 frames,
// LSB first. Read data follows the access by one cycle.
// Optional build macro: CONSOLE_UART_PARITY_EN adds an even-parity bit (8E1).
// Ports:
//   clk_i        clock, rising edge
//   rst_i        asynchronous active-high reset
//   addr_i       byte address, [3:2] select DATA/STAT/DIV/unused
//   wdata_cpu_i  CPU write data
//   wr_en_i      write strobe
//   stall_o      holds the CPU while a DATA write finds the FIFO full
//   data_cpu_o   read data for the address presented the previous cycle
//   tx_o         serial output, idle high
module console_uart_tx #(
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [3:0]  addr_i,
  input  logic [31:0] wdata_cpu_i,
  input  logic        wr_en_i,
  output logic        stall_o,
  output logic [31:0] data_cpu_o,
  output logic        tx_o
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef CONSOLE_UART_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_e;

  logic [1:0]    sel;
  logic          push, pop, flush, div_wr, full, empty;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [15:0]   div_q;
  logic [1:0]    addr_r_q;
  state_e        state_q;
  logic [7:0]    shift_q;
  logic [15:0]   div_l_q, baud_q;
  logic [2:0]    bit_q;
  logic          tx_q;
  logic [8:0]    count_ext;
  logic          unused_ok;
`ifdef CONSOLE_UART_PARITY_EN
  logic          par_q;
`endif

  assign unused_ok = ^{addr_i[1:0], wdata_cpu_i[31:16]};

  assign sel     = addr_i[3:2];
  assign full    = (count_q == (AW+1)'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  // full comes from the registered count, so a pop in this cycle cannot release the stall
  assign stall_o = wr_en_i && (sel == 2'd0) && full;
  assign push    = wr_en_i && (sel == 2'd0) && !full;
  assign flush   = wr_en_i && (sel == 2'd1) && wdata_cpu_i[0];
  assign div_wr  = wr_en_i && (sel == 2'd2);
  assign pop     = (state_q == S_IDLE) && !empty && !flush;
  assign tx_o    = tx_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= wdata_cpu_i[7:0];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      div_q    <= DEFAULT_DIV;
      addr_r_q <= '0;
    end else begin
      addr_r_q <= sel;
      if (div_wr) div_q <= (wdata_cpu_i[15:0] == '0) ? 16'd1 : wdata_cpu_i[15:0];
    end
  end

  // tx_q is registered from the current state, so the line lags the FSM by one
  // cycle uniformly; every bit still lasts exactly div_l cycles.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      div_l_q <= 16'd1;
      baud_q  <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
`ifdef CONSOLE_UART_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          tx_q <= 1'b1;
          if (pop) begin
            shift_q <= mem_q[rd_ptr_q];
            div_l_q <= div_q;
            baud_q  <= div_q - 1'b1;
`ifdef CONSOLE_UART_PARITY_EN
            par_q   <= ^mem_q[rd_ptr_q];
`endif
            state_q <= S_START;
          end
        end
        S_START: begin
          tx_q <= 1'b0;
          if (baud_q == '0) begin
            baud_q  <= div_l_q - 1'b1;
            bit_q   <= '0;
            state_q <= S_DATA;
          end else begin
            baud_q <= baud_q - 1'b1;
          end
        end
        S_DATA: begin
          tx_q <= shift_q[0];
          if (baud_q == '0) begin
            baud_q  <= div_l_q - 1'b1;
            shift_q <= {1'b0, shift_q[7:1]};
            if (bit_q == 3'd7) begin
`ifdef CONSOLE_UART_PARITY_EN
              state_q <= S_PARITY;
`else
              state_q <= S_STOP;
`endif
            end else begin
              bit_q <= bit_q + 1'b1;
            end
          end else begin
            baud_q <= baud_q - 1'b1;
          end
        end
`ifdef CONSOLE_UART_PARITY_EN
        S_PARITY: begin
          tx_q <= par_q;
          if (baud_q == '0) begin
            baud_q  <= div_l_q - 1'b1;
            state_q <= S_STOP;
          end else begin
            baud_q <= baud_q - 1'b1;
          end
        end
`endif
        S_STOP: begin
          tx_q <= 1'b1;
          if (baud_q == '0) state_q <= S_IDLE;
          else              baud_q  <= baud_q - 1'b1;
        end
        default: begin
          tx_q    <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign count_ext = 9'(count_q);

  always_comb begin
    data_cpu_o = '0;
    case (addr_r_q)
      2'd1: begin
        data_cpu_o[0]    = empty;
        data_cpu_o[1]    = full;
        data_cpu_o[2]    = (state_q != S_IDLE);
        data_cpu_o[15:8] = count_ext[7:0];
      end
      2'd2:    data_cpu_o[15:0] = div_q;
      default: data_cpu_o = '0;
    endcase
  end

endmodule

// File: tb/tb_console_uart_tx.sv
module tb_console_uart_tx;
  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [3:0]  addr_i;
  logic [31:0] wdata_cpu_i;
  logic        wr_en_i;
  logic        stall_o;
  logic [31:0] data_cpu_o;
  logic        tx_o;

  int checks = 0;
  int failures = 0;
  logic [7:0] sb[$];
  int  mon_div = 434;
  bit  mon_en = 1'b1;

`ifdef CONSOLE_UART_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  console_uart_tx #(.FIFO_DEPTH(16), .DEFAULT_DIV(16'd434)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .addr_i(addr_i), .wdata_cpu_i(wdata_cpu_i),
    .wr_en_i(wr_en_i), .stall_o(stall_o), .data_cpu_o(data_cpu_o), .tx_o(tx_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  // Entered and left 1 time unit after a rising edge.
  task automatic cpu_write(input logic [3:0] a, input logic [31:0] d, output int nst);
    nst = 0;
    addr_i = a; wdata_cpu_i = d; wr_en_i = 1'b1;
    #1;
    while (stall_o === 1'b1) begin
      nst++;
      if (nst > 1000) begin
        check("stall_timeout", 32'(nst), 32'd0);
        break;
      end
      @(posedge clk_i); #2;
    end
    if (a[3:2] == 2'd0) sb.push_back(d[7:0]);
    @(posedge clk_i); #1;
    wr_en_i = 1'b0;
  endtask

  task automatic cpu_read(input logic [3:0] a, output logic [31:0] v);
    addr_i = a; wr_en_i = 1'b0;
    tick();
    v = data_cpu_o;
  endtask

  task automatic set_div(input logic [31:0] v);
    int n;
    cpu_write(4'h8, v, n);
    mon_div = (v[15:0] == 16'd0) ? 1 : int'(v[15:0]);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 20000) begin tick(); n++; end
    if (sb.size() != 0) check(name, 32'(sb.size()), 32'd0);
    repeat (20) tick();
  endtask

  // Serial monitor: decodes frames with the divisor the bench last programmed.
  initial begin
    int d;
    logic [7:0] b;
    logic [7:0] e;
    logic s, p;
    p = 1'b0;
    forever begin
      @(posedge clk_i); #1;
      if (mon_en && tx_o === 1'b0) begin
        d = mon_div;
        for (int i = 0; i < 8; i++) begin
          repeat (d) begin @(posedge clk_i); #1; end
          b[i] = tx_o;
        end
`ifdef CONSOLE_UART_PARITY_EN
        repeat (d) begin @(posedge clk_i); #1; end
        p = tx_o;
`endif
        repeat (d) begin @(posedge clk_i); #1; end
        s = tx_o;
        if (sb.size() == 0) begin
          check("unexpected_frame", {24'd0, b}, 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          check("frame_byte", {24'd0, b}, {24'd0, e});
          check("stop_bit", {31'd0, s}, 32'd1);
`ifdef CONSOLE_UART_PARITY_EN
          check("parity_bit", {31'd0, p}, {31'd0, ^e});
`endif
        end
      end
    end
  end

  typedef struct {
    bit          wr;
    logic [3:0]  waddr;
    logic [31:0] wdata;
    logic [3:0]  raddr;
    logic [31:0] exp;
    string       name;
  } vec_t;

  initial begin
    vec_t vt[10];
    logic [31:0] v;
    logic wexp[$];
    int n;
    int st[20];
    logic [7:0] b55;

    vt[0] = '{0, 4'h0, 32'h0,          4'h4, 32'h1,    "stat_reset"};
    vt[1] = '{0, 4'h0, 32'h0,          4'h8, 32'd434,  "div_reset"};
    vt[2] = '{0, 4'h0, 32'h0,          4'h0, 32'h0,    "data_reads_0"};
    vt[3] = '{0, 4'h0, 32'h0,          4'hC, 32'h0,    "reg3_reads_0"};
    vt[4] = '{1, 4'h8, 32'h0,          4'h8, 32'h1,    "div_zero_as_1"};
    vt[5] = '{1, 4'h8, 32'hABCD_1234,  4'h8, 32'h1234, "div_low16"};
    vt[6] = '{1, 4'hC, 32'hFFFF_FFFF,  4'h8, 32'h1234, "reg3_write_ignored"};
    vt[7] = '{1, 4'h4, 32'hFFFF_FFFE,  4'h4, 32'h1,    "stat_write_nobit0"};
    vt[8] = '{1, 4'h4, 32'h1,          4'h4, 32'h1,    "flush_empty"};
    vt[9] = '{0, 4'h0, 32'h0,          4'h9, 32'h1234, "div_alias_lowbits"};

    rst_i = 1'b1; addr_i = '0; wdata_cpu_i = '0; wr_en_i = 1'b0;
    tick(); tick();
    check("rst_tx", {31'd0, tx_o}, 32'd1);
    check("rst_stall", {31'd0, stall_o}, 32'd0);
    check("rst_data", data_cpu_o, 32'd0);
    rst_i = 1'b0;
    tick();

    // Register-level vectors
    for (int i = 0; i < 10; i++) begin
      if (vt[i].wr) cpu_write(vt[i].waddr, vt[i].wdata, n);
      cpu_read(vt[i].raddr, v);
      check(vt[i].name, v, vt[i].exp);
    end
    check("tx_idle_after_regs", {31'd0, tx_o}, 32'd1);

    // Exact waveform for 0x55 at DIV=4
    set_div(32'd4);
    b55 = 8'h55;
    wexp.push_back(1'b1); wexp.push_back(1'b1);
    repeat (4) wexp.push_back(1'b0);
    for (int i = 0; i < 8; i++) repeat (4) wexp.push_back(b55[i]);
`ifdef CONSOLE_UART_PARITY_EN
    repeat (4) wexp.push_back(^b55);
`endif
    repeat (4) wexp.push_back(1'b1);
    wexp.push_back(1'b1);
    cpu_write(4'h0, 32'h55, n);
    for (int i = 0; i < 2 + 4 * NB + 1; i++) begin
      if (i != 0) tick();
      check($sformatf("wave55[%0d]", i), {31'd0, tx_o}, {31'd0, wexp[i]});
    end
    wait_drain("drain_55");

    // DIV=0 acts as 1 cycle per bit; parity patterns 0x07 and 0x03 included
    set_div(32'd0);
    cpu_read(4'h8, v);
    check("div0_readback", v, 32'd1);
    cpu_write(4'h0, 32'h07, n);
    cpu_write(4'h0, 32'h03, n);
    cpu_write(4'h0, 32'hC3, n);
    cpu_write(4'h0, 32'h00, n);
    cpu_write(4'h0, 32'hFF, n);
    wait_drain("drain_div1");

    // Overflow: 20 back-to-back writes at DIV=1
    set_div(32'd1);
    for (int k = 0; k < 20; k++) cpu_write(4'h0, 32'(k * 13 + 1), st[k]);
    check("no_stall_k17", 32'(st[17]), 32'd0);
    check("stall_k18", 32'(st[18]), 32'd6);
    check("stall_k19_nonzero", 32'(st[19] > 0), 32'd1);
    wait_drain("drain_overflow");
    cpu_read(4'h4, v);
    check("stat_after_overflow", v, 32'h1);

    // Flush mid-frame at DIV=4
    set_div(32'd4);
    for (int k = 0; k < 5; k++) cpu_write(4'h0, 32'h30 + 32'(k), n);
    repeat (8) tick();
    cpu_read(4'h4, v);
    check("stat_before_flush", v, 32'h0000_0404);
    cpu_write(4'h4, 32'h1, n);
    while (sb.size() > 1) void'(sb.pop_back());
    cpu_read(4'h4, v);
    check("stat_after_flush", v, 32'h0000_0005);
    wait_drain("drain_flush");
    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle_after_flush", {31'd0, tx_o}, 32'd1);
    end
    cpu_read(4'h4, v);
    check("stat_idle_after_flush", v, 32'h1);

    // Reset during DATA bit 3 of 0xA5 (bit 3 is 0)
    mon_en = 1'b0;
    cpu_write(4'h0, 32'hA5, n);
    sb.delete();
    repeat (19) tick();
    check("bit3_before_rst", {31'd0, tx_o}, 32'd0);
    rst_i = 1'b1;
    #1;
    check("tx_high_on_rst", {31'd0, tx_o}, 32'd1);
    tick();
    rst_i = 1'b0;
    mon_div = 434;
    cpu_read(4'h4, v);
    check("stat_after_rst", v, 32'h1);
    cpu_read(4'h8, v);
    check("div_after_rst", v, 32'd434);
    repeat (10) tick();
    check("tx_idle_after_rst", {31'd0, tx_o}, 32'd1);
    mon_en = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
